tx_block_scheduler: RTL and testbench

Sequencing controller in front of the 130-bit TX serializer. Arbitrates between a data-block source, an ordered-set source and an internal SKP timer. Frames each winner as a 130-bit block: 2-bit sync header plus 128-bit payload. Issues one load per block and waits for the serializer to drain before issuing the next.

---
 rtl/phy_tx_pkg.sv | 31 +++
 rtl/tx_src_arbiter.sv | 39 +++
 rtl/tx_block_scheduler.sv | 148 ++++++++++++++
 tb/tb_tx_block_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// Shared types and constants for the TX block path: block types, sync headers,
// the SKP ordered-set payload and the scheduler FSM encoding.
package phy_tx_pkg;

  localparam int PAYLOAD_W = 128;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_OS   = 2'b10;

  localparam logic [PAYLOAD_W-1:0] SKP_PAYLOAD = {{15{8'hAA}}, 8'hE1};

  typedef enum logic [1:0] {
    IDLE_BLK = 2'd0,
    DATA_BLK = 2'd1,
    OS_BLK   = 2'd2,
    SKP_BLK  = 2'd3
  } blk_type_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_SHIFT     = 2'd3
  } tx_state_e;

  // Data and idle filler share one header; OS and SKP share the other.
  function automatic logic [1:0] sync_of(input blk_type_e t);
    return (t == OS_BLK || t == SKP_BLK) ? SYNC_OS : SYNC_DATA;
  endfunction

endpackage

// File: rtl/tx_src_arbiter.sv
// Fixed-priority source select: SKP > OS > data > idle filler.
// Purely combinational; grant is one-hot indexed by blk_type_e.
module tx_src_arbiter
  import phy_tx_pkg::*;
#(
  parameter int PW = 128
) (
  input  logic          skp_pend_i,
  input  logic          os_valid_i,
  input  logic          data_valid_i,
  input  logic [PW-1:0] os_in_i,
  input  logic [PW-1:0] data_in_i,
  output logic [3:0]    gnt_o,
  output logic [1:0]    sync_o,
  output logic [PW-1:0] payload_o
);

  blk_type_e sel;

  always_comb begin
    if (skp_pend_i)        sel = SKP_BLK;
    else if (os_valid_i)   sel = OS_BLK;
    else if (data_valid_i) sel = DATA_BLK;
    else                   sel = IDLE_BLK;
  end

  always_comb begin
    gnt_o      = '0;
    gnt_o[sel] = 1'b1;
    sync_o     = sync_of(sel);
    unique case (sel)
      SKP_BLK:  payload_o = SKP_PAYLOAD[PW-1:0];
      OS_BLK:   payload_o = os_in_i;
      DATA_BLK: payload_o = data_in_i;
      default:  payload_o = '0;
    endcase
  end

endmodule

// File: rtl/tx_block_scheduler.sv
// Block sequencer in front of the TX serializer: picks a source, frames it with
// a sync header, issues one load strobe and waits for the serializer to drain.
module tx_block_scheduler
  import phy_tx_pkg::*;
#(
  parameter int WIDTH        = 130,
  parameter int SKP_INTERVAL = 370,
  parameter int CNT_W        = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             link_en,
  input  logic             data_valid,
  input  logic [WIDTH-3:0] data_in,
  output logic             data_ready,
  input  logic             os_valid,
  input  logic [WIDTH-3:0] os_in,
  output logic             os_ready,
  output logic [WIDTH-1:0] ser_par,
  output logic             ser_load,
  input  logic             ser_busy,
  output logic [1:0]       blk_type,
  output logic             blk_sent,
  output logic             err_no_busy
);

  localparam int PW = WIDTH - 2;
  localparam logic [CNT_W-1:0] SKP_MAX = CNT_W'(SKP_INTERVAL);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] skp_cnt_q, skp_cnt_d;
  logic             wb_cnt_q, wb_cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] par_q, par_d;
  blk_type_e        type_q, type_d;
  logic             load_q, load_d;
  logic             dr_q, dr_d;
  logic             or_q, or_d;

  logic             skp_pend;
  logic [3:0]       sel_gnt;
  logic [1:0]       sel_sync;
  logic [PW-1:0]    sel_payload;
  blk_type_e        sel_type;

  assign skp_pend = (skp_cnt_q == SKP_MAX);

  tx_src_arbiter #(.PW(PW)) u_arb (
    .skp_pend_i   (skp_pend),
    .os_valid_i   (os_valid),
    .data_valid_i (data_valid),
    .os_in_i      (os_in),
    .data_in_i    (data_in),
    .gnt_o        (sel_gnt),
    .sync_o       (sel_sync),
    .payload_o    (sel_payload)
  );

  always_comb begin
    unique case (sel_gnt)
      4'b0010: sel_type = DATA_BLK;
      4'b0100: sel_type = OS_BLK;
      4'b1000: sel_type = SKP_BLK;
      default: sel_type = IDLE_BLK;
    endcase
  end

  // Load-cycle outputs are computed on the IDLE->LOAD edge so they appear
  // registered during the LOAD cycle itself.
  always_comb begin
    state_d   = state_q;
    skp_cnt_d = skp_cnt_q;
    wb_cnt_d  = wb_cnt_q;
    err_d     = err_q;
    par_d     = par_q;
    type_d    = type_q;
    load_d    = 1'b0;
    dr_d      = 1'b0;
    or_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!link_en) begin
          skp_cnt_d = '0;
        end else if (!ser_busy) begin
          state_d = ST_LOAD;
          par_d   = {sel_sync, sel_payload};
          type_d  = sel_type;
          load_d  = 1'b1;
          dr_d    = sel_gnt[DATA_BLK];
          or_d    = sel_gnt[OS_BLK];
          if (sel_gnt[SKP_BLK])    skp_cnt_d = '0;
          else if (!skp_pend)      skp_cnt_d = skp_cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        state_d  = ST_WAIT_BUSY;
        wb_cnt_d = 1'b0;
      end
      ST_WAIT_BUSY: begin
        if (ser_busy) begin
          state_d = ST_SHIFT;
        end else if (wb_cnt_q) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wb_cnt_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!ser_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      skp_cnt_q <= '0;
      wb_cnt_q  <= 1'b0;
      err_q     <= 1'b0;
      par_q     <= '0;
      type_q    <= IDLE_BLK;
      load_q    <= 1'b0;
      dr_q      <= 1'b0;
      or_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      skp_cnt_q <= skp_cnt_d;
      wb_cnt_q  <= wb_cnt_d;
      err_q     <= err_d;
      par_q     <= par_d;
      type_q    <= type_d;
      load_q    <= load_d;
      dr_q      <= dr_d;
      or_q      <= or_d;
    end
  end

  assign ser_par     = par_q;
  assign ser_load    = load_q;
  assign blk_sent    = load_q;
  assign blk_type    = type_q;
  assign data_ready  = dr_q;
  assign os_ready    = or_q;
  assign err_no_busy = err_q;

endmodule

// File: tb/tb_tx_block_scheduler.sv
// Directed bench for tx_block_scheduler with a simple serializer model that
// stays busy for B cycles after each load (or never, in fault mode).
module tb_tx_block_scheduler;

  localparam int W  = 130;
  localparam int B  = 4;
  localparam int BP = B + 3;

  logic           clk = 1'b0;
  logic           rst_n, link_en, data_valid, os_valid, ser_busy;
  logic [W-3:0]   data_in, os_in;
  logic           data_ready, os_ready, ser_load, blk_sent, err_no_busy;
  logic [W-1:0]   ser_par;
  logic [1:0]     blk_type;
  logic           ser_dead;
  int             bcnt;
  int             cyc = 0;

  tx_block_scheduler #(.WIDTH(W), .SKP_INTERVAL(4), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .link_en(link_en),
    .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
    .os_valid(os_valid), .os_in(os_in), .os_ready(os_ready),
    .ser_par(ser_par), .ser_load(ser_load), .ser_busy(ser_busy),
    .blk_type(blk_type), .blk_sent(blk_sent), .err_no_busy(err_no_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n)                     bcnt <= 0;
    else if (ser_load && !ser_dead) bcnt <= B;
    else if (bcnt != 0)             bcnt <= bcnt - 1;
  end
  assign ser_busy = (bcnt != 0);

  typedef struct {
    logic [1:0]   t;
    logic [W-1:0] par;
    logic         dr;
    logic         orr;
    int           cyc;
  } ld_t;
  ld_t lds[$];
  int  stray = 0;

  always @(negedge clk) begin
    if (ser_load) lds.push_back('{blk_type, ser_par, data_ready, os_ready, cyc});
    if ((data_ready || os_ready || blk_sent) && !ser_load) stray++;
    if (ser_load && !blk_sent) stray++;
  end

  int n_chk = 0, n_fail = 0, base = 0;

  localparam logic [127:0] D_PAY = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] O_PAY = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] S_PAY = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAE1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_loads(input int n);
    int b = 0;
    while (lds.size() < base + n && b < 200) begin
      step(1);
      b++;
    end
    if (lds.size() < base + n) chk("load_timeout", W'(lds.size() - base), W'(n));
  endtask

  task automatic reset_hold();
    rst_n = 1'b0; link_en = 1'b0; data_valid = 1'b0; os_valid = 1'b0;
    step(2);
  endtask

  task automatic release_rst();
    rst_n = 1'b1; link_en = 1'b1;
    base = lds.size();
  endtask

  initial begin
    logic [1:0]   exp_t[7];
    logic [W-1:0] idle_par;
    idle_par = {2'b01, 128'h0};
    exp_t = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd1};
    data_in = '0; os_in = '0; ser_dead = 1'b0;

    // Reset values
    reset_hold();
    chk("rst_par",  ser_par,          '0);
    chk("rst_load", W'(ser_load),     '0);
    chk("rst_sent", W'(blk_sent),     '0);
    chk("rst_type", W'(blk_type),     '0);
    chk("rst_err",  W'(err_no_busy),  '0);
    chk("rst_rdy",  W'({data_ready, os_ready}), '0);

    // Idle fill with B+3 period
    release_rst();
    wait_loads(3);
    chk("idle_par0",  lds[base].par,      idle_par);
    chk("idle_type0", W'(lds[base].t),    W'(0));
    chk("idle_par2",  lds[base+2].par,    idle_par);
    chk("idle_per1",  W'(lds[base+1].cyc - lds[base].cyc),   W'(BP));
    chk("idle_per2",  W'(lds[base+2].cyc - lds[base+1].cyc), W'(BP));

    // Single data block, loaded one cycle after reset release
    reset_hold();
    data_in = D_PAY; data_valid = 1'b1;
    release_rst();
    step(1);
    chk("data_lat_load", W'(ser_load), W'(1));
    wait_loads(1);
    data_valid = 1'b0;
    wait_loads(2);
    chk("data_par",   lds[base].par,     {2'b01, D_PAY});
    chk("data_type",  W'(lds[base].t),   W'(1));
    chk("data_rdy",   W'({lds[base].dr, lds[base].orr}), W'(2'b10));
    chk("data_next_type", W'(lds[base+1].t), W'(0));
    chk("data_next_rdy",  W'(lds[base+1].dr), W'(0));

    // OS and data contend: OS first, data next
    reset_hold();
    data_in = D_PAY; data_valid = 1'b1; os_in = O_PAY; os_valid = 1'b1;
    release_rst();
    wait_loads(1);
    os_valid = 1'b0;
    wait_loads(2);
    data_valid = 1'b0;
    chk("cont_os_par",  lds[base].par,   {2'b10, O_PAY});
    chk("cont_os_type", W'(lds[base].t), W'(2));
    chk("cont_os_rdy",  W'({lds[base].dr, lds[base].orr}), W'(2'b01));
    chk("cont_d_par",   lds[base+1].par, {2'b01, D_PAY});
    chk("cont_d_rdy",   W'({lds[base+1].dr, lds[base+1].orr}), W'(2'b10));

    // SKP every 4 non-SKP blocks, and it beats a pending OS
    reset_hold();
    data_in = D_PAY; data_valid = 1'b1; os_in = O_PAY;
    release_rst();
    wait_loads(4);
    os_valid = 1'b1;
    wait_loads(6);
    os_valid = 1'b0;
    wait_loads(7);
    data_valid = 1'b0;
    for (int i = 0; i < 7; i++)
      chk($sformatf("skp_type%0d", i), W'(lds[base+i].t), W'(exp_t[i]));
    chk("skp_par",   lds[base+4].par,      {2'b10, S_PAY});
    chk("skp_osrdy", W'(lds[base+4].orr),  W'(0));
    chk("skp_os_par", lds[base+5].par,     {2'b10, O_PAY});

    // Serializer never goes busy
    reset_hold();
    ser_dead = 1'b1;
    release_rst();
    wait_loads(1);
    chk("flt_err_early", W'(err_no_busy), W'(0));
    step(3);
    chk("flt_err_set", W'(err_no_busy), W'(1));
    wait_loads(2);
    chk("flt_reidle", W'(lds[base+1].cyc - lds[base].cyc), W'(4));
    step(10);
    chk("flt_sticky", W'(err_no_busy), W'(1));
    reset_hold();
    ser_dead = 1'b0;
    chk("flt_rst_clr", W'(err_no_busy), W'(0));

    // link_en dropped mid-SHIFT: block finishes, no further load
    release_rst();
    wait_loads(1);
    step(3);
    link_en = 1'b0;
    step(20);
    chk("dis_loads", W'(lds.size() - base), W'(1));
    chk("dis_busy",  W'(ser_busy), W'(0));

    // Reset mid-SHIFT
    link_en = 1'b1;
    base = lds.size();
    wait_loads(1);
    step(3);
    chk("mid_busy", W'(ser_busy), W'(1));
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_par",  ser_par, '0);
    chk("mid_rst_type", W'(blk_type), W'(0));
    chk("mid_rst_load", W'({ser_load, blk_sent, data_ready, os_ready}), W'(0));
    rst_n = 1'b1;
    step(1);
    chk("mid_rst_idle", W'(ser_load), W'(1));
    chk("mid_rst_par2", ser_par, idle_par);

    chk("stray_pulses", W'(stray), W'(0));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
